lc3b_ctrl_pipe: RTL and testbench
=================================

LC3B_CTRL_PIPE -- requirements
Module: lc3b_ctrl_pipe

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of tracked stages after decode (legal 2..8; stage 0 = EX, stage DEPTH-1 = WB).
REQ-002 SHALL have parameter FLUSH_STAGE, default 2, number of youngest stages squashed by flush (legal 1..DEPTH-1).
REQ-003 SHALL have parameter CTRL_W, default $bits(lc3b_control), control-word width.
REQ-004 SHALL have one clock and an asynchronous active-low reset, with ports clk (in, 1, rising-edge clock) and reset_n (in, 1, async active-low reset).
REQ-005 SHALL have ports: in_valid in 1, decoded instruction present; in_ctrl in CTRL_W, control word; in_dest in 3, destination reg; in_we in 1, writes register; in_is_load in 1, memory load; in_src1/in_src2 in 3, source regs; in_use in 2, bit i = srci read.
REQ-006 SHALL have ports: stall in 1, freeze pipe (memory not ready); flush in 1, branch/redirect resolved.
REQ-007 SHALL have ports: in_ready out 1, decode accepted this cycle; stg_valid out DEPTH; stg_ctrl out DEPTH x CTRL_W; stg_dest out DEPTH x 3.
REQ-008 SHALL have ports: fwd1_hit/fwd2_hit out 1; fwd1_stg/fwd2_stg out $clog2(DEPTH), forwarding source stage.
REQ-009 SHALL have ports: bubble_cnt out 16; flush_cnt out 16; retire_cnt out 16.

Function
REQ-010 Each stage SHALL hold an entry: valid, ctrl, dest, we, is_load.
REQ-011 With stall=0, every stage SHALL advance each cycle: stage k takes stage k-1 (k>=1), and stage 0 takes the input entry if in_valid & in_ready; otherwise it takes a bubble (valid=0, ctrl=0).
REQ-012 With stall=1, all stages SHALL hold, and in_ready SHALL be 0.
REQ-013 A load-use hazard SHALL be declared when in_valid, stage 0 is valid & we & is_load, and stage-0 dest equals any source enabled by in_use.
REQ-014 in_ready SHALL be ~stall & ~hazard & ~flush (combinational).
REQ-015 On hazard with stall=0, stage 0 SHALL receive a bubble, older stages SHALL advance, and bubble_cnt SHALL increment.
REQ-016 On flush with stall=0, the pipe SHALL advance, then stages 0..FLUSH_STAGE-1 SHALL be written invalid with ctrl=0 in the same edge; the input SHALL not be accepted.
REQ-017 On flush with stall=1, stages 0..FLUSH_STAGE-1 SHALL be invalidated and older stages SHALL hold; flush SHALL win over stall for the squashed stages.
REQ-018 flush_cnt SHALL increment once per cycle with flush=1.
REQ-019 retire_cnt SHALL increment when stall=0 and stage DEPTH-1 is valid.
REQ-020 All three counters SHALL saturate at 16'hFFFF with no wrap.
REQ-021 fwdN_hit SHALL be 1 when srcN is used and some stage k is valid & we & dest==srcN; stage 0 SHALL qualify only if not is_load.
REQ-022 fwdN_stg SHALL be the lowest (youngest) qualifying k, and 0 when there is no hit.
REQ-023 Forwarding and hazard outputs SHALL be purely combinational from current stage state and inputs; there SHALL be no added latency.

Reset
REQ-024 reset_n low SHALL immediately clear all stg_valid, stg_ctrl, stg_dest, we, is_load and all counters to 0.
REQ-025 After reset, in_ready SHALL be 1 whenever stall=0 and flush=0.
REQ-026 Reset asserted mid-hazard or mid-flush SHALL discard all in-flight entries; there SHALL be no replay.

Structure
REQ-027 The stage entry struct (valid, lc3b_control ctrl, lc3b_reg dest, we, is_load) and a 16-bit counter typedef SHALL be added to package lc3b_types.
REQ-028 Match/priority logic SHALL live in one sub-module, lc3b_fwd_unit, instantiated once per source operand.
REQ-029 The stage array SHALL be a generate-sized register array; DEPTH and FLUSH_STAGE SHALL be checked by elaboration-time assertions.

Verification (DEPTH=4, FLUSH_STAGE=2)
REQ-030 ADD R1 then ADD R2,R1,R1 back-to-back -> no bubble; fwd1_hit=1, fwd1_stg=0, bubble_cnt stays 0.
REQ-031 LDR R3 then ADD R4,R3,R0 -> in_ready=0 for one cycle, stg_valid=4'b0010 next cycle, bubble_cnt=1, ADD accepted the following cycle with fwd1_stg=1.
REQ-032 Four valid instructions, then flush=1 with stall=0 -> stg_valid goes from 4'b1111 to 4'b1100, flush_cnt=1, input not taken.
REQ-033 stall=1 for 3 cycles with a full pipe -> stg_ctrl unchanged, retire_cnt unchanged; stall plus flush -> stages 0/1 invalid, stages 2/3 held.
REQ-034 Preload retire_cnt near 16'hFFFF and run 5 retirements -> holds 16'hFFFF.
REQ-035 Deassert reset_n asynchronously mid-stream between clock edges -> all outputs 0 immediately; first post-reset instruction appears in stage 0 one edge after release.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b types: control word, register index, pipeline stage entry and
// saturating 16-bit event counter.
package lc3b_types;

    typedef logic [2:0]  lc3b_reg;
    typedef logic [15:0] lc3b_cnt16;

    typedef struct packed {
        logic [3:0] opcode;
        logic [2:0] aluop;
        logic       load_regfile;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] pcmux_sel;
    } lc3b_control;

    typedef struct packed {
        logic        valid;
        lc3b_control ctrl;
        lc3b_reg     dest;
        logic        we;
        logic        is_load;
    } lc3b_stage_entry;

    function automatic lc3b_cnt16 sat_inc(input lc3b_cnt16 c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

endpackage

// File: rtl/lc3b_fwd_unit.sv
// Forwarding match for one source operand: youngest qualifying stage wins.
module lc3b_fwd_unit
    import lc3b_types::*;
#(
    parameter  int DEPTH = 4,
    localparam int SW    = $clog2(DEPTH)
) (
    input  lc3b_reg                src,
    input  logic                   use_src,
    input  logic [DEPTH-1:0]       cand_valid,
    input  logic [DEPTH-1:0][2:0]  cand_dest,
    output logic                   hit,
    output logic [SW-1:0]          stg
);

    logic [DEPTH-1:0] match;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match[gi] = use_src & cand_valid[gi] & (cand_dest[gi] == src);
        end
    endgenerate

    // Scan oldest to youngest so the lowest matching index is left in stg.
    always_comb begin
        hit = |match;
        stg = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match[k]) stg = SW'(k);
        end
    end

endmodule

// File: rtl/lc3b_ctrl_pipe.sv
// Control-word pipeline after decode with load-use interlock, flush squash,
// register forwarding selection and saturating bubble/flush/retire counters.
module lc3b_ctrl_pipe
    import lc3b_types::*;
#(
    parameter  int DEPTH       = 4,
    parameter  int FLUSH_STAGE = 2,
    parameter  int CTRL_W      = $bits(lc3b_control),
    localparam int SW          = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    input  logic [CTRL_W-1:0]           in_ctrl,
    input  logic [2:0]                  in_dest,
    input  logic                        in_we,
    input  logic                        in_is_load,
    input  logic [2:0]                  in_src1,
    input  logic [2:0]                  in_src2,
    input  logic [1:0]                  in_use,
    input  logic                        stall,
    input  logic                        flush,
    output logic                        in_ready,
    output logic [DEPTH-1:0]            stg_valid,
    output logic [DEPTH-1:0][CTRL_W-1:0] stg_ctrl,
    output logic [DEPTH-1:0][2:0]       stg_dest,
    output logic                        fwd1_hit,
    output logic                        fwd2_hit,
    output logic [SW-1:0]               fwd1_stg,
    output logic [SW-1:0]               fwd2_stg,
    output logic [15:0]                 bubble_cnt,
    output logic [15:0]                 flush_cnt,
    output logic [15:0]                 retire_cnt
);

    generate
        if (DEPTH < 2 || DEPTH > 8) begin : g_bad_depth
            $error("lc3b_ctrl_pipe: DEPTH must be 2..8");
        end
        if (FLUSH_STAGE < 1 || FLUSH_STAGE > DEPTH - 1) begin : g_bad_flush
            $error("lc3b_ctrl_pipe: FLUSH_STAGE must be 1..DEPTH-1");
        end
        if (CTRL_W != $bits(lc3b_control)) begin : g_bad_ctrl
            $error("lc3b_ctrl_pipe: CTRL_W must match lc3b_control");
        end
    endgenerate

    lc3b_stage_entry stage_reg [DEPTH];
    lc3b_stage_entry stage_src [DEPTH];
    lc3b_stage_entry in_entry;
    logic            hazard;
    logic [DEPTH-1:0] cand_valid;
    lc3b_cnt16       bubble_cnt_reg, flush_cnt_reg, retire_cnt_reg;

    // Only a load still in EX cannot forward; that case becomes an interlock.
    assign hazard = in_valid & stage_reg[0].valid & stage_reg[0].we & stage_reg[0].is_load &
                    ((in_use[0] & (stage_reg[0].dest == in_src1)) |
                     (in_use[1] & (stage_reg[0].dest == in_src2)));

    assign in_ready = ~stall & ~hazard & ~flush;

    always_comb begin
        in_entry = '0;
        if (in_valid && in_ready) begin
            in_entry.valid   = 1'b1;
            in_entry.ctrl    = lc3b_control'(in_ctrl);
            in_entry.dest    = in_dest;
            in_entry.we      = in_we;
            in_entry.is_load = in_is_load;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            localparam bit SQUASH = (gi < FLUSH_STAGE);

            if (gi == 0) begin : g_head
                assign stage_src[gi]  = in_entry;
                assign cand_valid[gi] = stage_reg[gi].valid & stage_reg[gi].we & ~stage_reg[gi].is_load;
            end else begin : g_body
                assign stage_src[gi]  = stage_reg[gi-1];
                assign cand_valid[gi] = stage_reg[gi].valid & stage_reg[gi].we;
            end

            // Flush overrides stall on the youngest stages; older ones obey stall.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    stage_reg[gi] <= '0;
                end else if (flush && SQUASH) begin
                    stage_reg[gi] <= '0;
                end else if (!stall) begin
                    stage_reg[gi] <= stage_src[gi];
                end
            end

            assign stg_valid[gi] = stage_reg[gi].valid;
            assign stg_ctrl[gi]  = CTRL_W'(stage_reg[gi].ctrl);
            assign stg_dest[gi]  = stage_reg[gi].dest;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bubble_cnt_reg <= '0;
            flush_cnt_reg  <= '0;
            retire_cnt_reg <= '0;
        end else begin
            if (hazard && !stall)                        bubble_cnt_reg <= sat_inc(bubble_cnt_reg);
            if (flush)                                   flush_cnt_reg  <= sat_inc(flush_cnt_reg);
            if (!stall && stage_reg[DEPTH-1].valid)      retire_cnt_reg <= sat_inc(retire_cnt_reg);
        end
    end

    assign bubble_cnt = bubble_cnt_reg;
    assign flush_cnt  = flush_cnt_reg;
    assign retire_cnt = retire_cnt_reg;

    lc3b_fwd_unit #(.DEPTH(DEPTH)) u_fwd1 (
        .src        (in_src1),
        .use_src    (in_use[0]),
        .cand_valid (cand_valid),
        .cand_dest  (stg_dest),
        .hit        (fwd1_hit),
        .stg        (fwd1_stg)
    );

    lc3b_fwd_unit #(.DEPTH(DEPTH)) u_fwd2 (
        .src        (in_src2),
        .use_src    (in_use[1]),
        .cand_valid (cand_valid),
        .cand_dest  (stg_dest),
        .hit        (fwd2_hit),
        .stg        (fwd2_stg)
    );

endmodule

// File: tb/tb_lc3b_ctrl_pipe.sv
// Directed bench for lc3b_ctrl_pipe (DEPTH=4, FLUSH_STAGE=2) with
// hand-computed expectations checked by immediate assertions.
module tb_lc3b_ctrl_pipe;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic [11:0]      in_ctrl;
    logic [2:0]       in_dest;
    logic             in_we;
    logic             in_is_load;
    logic [2:0]       in_src1;
    logic [2:0]       in_src2;
    logic [1:0]       in_use;
    logic             stall;
    logic             flush;
    logic             in_ready;
    logic [3:0]       stg_valid;
    logic [3:0][11:0] stg_ctrl;
    logic [3:0][2:0]  stg_dest;
    logic             fwd1_hit, fwd2_hit;
    logic [1:0]       fwd1_stg, fwd2_stg;
    logic [15:0]      bubble_cnt, flush_cnt, retire_cnt;

    int checks = 0;
    int errors = 0;

    localparam logic [11:0] C_ADD1 = 12'h101;
    localparam logic [11:0] C_ADD2 = 12'h102;
    localparam logic [11:0] C_LDR  = 12'h6A4;
    localparam logic [11:0] C_ADD4 = 12'h104;
    localparam logic [11:0] C_A = 12'hA0A, C_B = 12'hB0B, C_C = 12'hC0C, C_D = 12'hD0D, C_E = 12'hE0E;
    localparam logic [11:0] C_F = 12'h1F1, C_G = 12'h2E2, C_H = 12'h3D3, C_I = 12'h4C4, C_J = 12'h5B5;
    localparam logic [11:0] C_K = 12'h7A7;

    always #5 clk = ~clk;

    lc3b_ctrl_pipe dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ctrl    (in_ctrl),
        .in_dest    (in_dest),
        .in_we      (in_we),
        .in_is_load (in_is_load),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_use     (in_use),
        .stall      (stall),
        .flush      (flush),
        .in_ready   (in_ready),
        .stg_valid  (stg_valid),
        .stg_ctrl   (stg_ctrl),
        .stg_dest   (stg_dest),
        .fwd1_hit   (fwd1_hit),
        .fwd2_hit   (fwd2_hit),
        .fwd1_stg   (fwd1_stg),
        .fwd2_stg   (fwd2_stg),
        .bubble_cnt (bubble_cnt),
        .flush_cnt  (flush_cnt),
        .retire_cnt (retire_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [11:0] c, input logic [2:0] d, input logic we, input logic ld,
                         input logic [2:0] s1, input logic [2:0] s2, input logic [1:0] u);
        in_valid = 1'b1; in_ctrl = c; in_dest = d; in_we = we; in_is_load = ld;
        in_src1 = s1; in_src2 = s2; in_use = u;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_ctrl = '0; in_dest = '0; in_we = 1'b0; in_is_load = 1'b0;
        in_src1 = '0; in_src2 = '0; in_use = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; stall = 1'b0; flush = 1'b0;
        idle();
        #12;
        chk("reset_valid",  32'(stg_valid), 32'h0);
        chk("reset_ctrl0",  32'(stg_ctrl[0]), 32'h0);
        chk("reset_bubble", 32'(bubble_cnt), 32'h0);
        chk("reset_flush",  32'(flush_cnt), 32'h0);
        chk("reset_retire", 32'(retire_cnt), 32'h0);
        #10;                                   // t=22, between edges
        reset_n = 1'b1;
        #1;
        chk("ready_after_reset", 32'(in_ready), 32'h1);

        // ADD R1 then ADD R2,R1,R1: forward from EX, no bubble
        issue(C_ADD1, 3'd1, 1'b1, 1'b0, 3'd5, 3'd6, 2'b11);
        tick();
        issue(C_ADD2, 3'd2, 1'b1, 1'b0, 3'd1, 3'd1, 2'b11);
        #1;
        chk("raw_ready",    32'(in_ready), 32'h1);
        chk("raw_fwd1_hit", 32'(fwd1_hit), 32'h1);
        chk("raw_fwd1_stg", 32'(fwd1_stg), 32'h0);
        chk("raw_fwd2_hit", 32'(fwd2_hit), 32'h1);
        tick();
        chk("raw_valid",  32'(stg_valid), 32'h3);
        chk("raw_dest0",  32'(stg_dest[0]), 32'h2);
        chk("raw_bubble", 32'(bubble_cnt), 32'h0);
        idle();
        repeat (4) tick();
        chk("drain_valid",  32'(stg_valid), 32'h0);
        chk("drain_retire", 32'(retire_cnt), 32'd2);

        // LDR R3 then ADD R4,R3,R0: one interlock bubble
        issue(C_LDR, 3'd3, 1'b1, 1'b1, 3'd2, 3'd0, 2'b01);
        tick();
        issue(C_ADD4, 3'd4, 1'b1, 1'b0, 3'd3, 3'd0, 2'b11);
        #1;
        chk("lu_ready_low", 32'(in_ready), 32'h0);
        tick();
        chk("lu_valid",  32'(stg_valid), 32'h2);
        chk("lu_bubble", 32'(bubble_cnt), 32'h1);
        chk("lu_ready",    32'(in_ready), 32'h1);
        chk("lu_fwd1_hit", 32'(fwd1_hit), 32'h1);
        chk("lu_fwd1_stg", 32'(fwd1_stg), 32'h1);
        chk("lu_fwd2_hit", 32'(fwd2_hit), 32'h0);
        tick();
        chk("lu_valid2", 32'(stg_valid), 32'h5);
        chk("lu_dest0",  32'(stg_dest[0]), 32'h4);

        // Fill with four, then flush with stall=0
        issue(C_A, 3'd5, 1'b0, 1'b0, 3'd0, 3'd0, 2'b00); tick();
        issue(C_B, 3'd5, 1'b0, 1'b0, 3'd0, 3'd0, 2'b00); tick();
        issue(C_C, 3'd5, 1'b0, 1'b0, 3'd0, 3'd0, 2'b00); tick();
        issue(C_D, 3'd5, 1'b0, 1'b0, 3'd0, 3'd0, 2'b00); tick();
        chk("fill_valid",  32'(stg_valid), 32'hF);
        chk("fill_retire", 32'(retire_cnt), 32'd4);
        issue(C_E, 3'd5, 1'b0, 1'b0, 3'd0, 3'd0, 2'b00);
        flush = 1'b1;
        #1;
        chk("flush_ready", 32'(in_ready), 32'h0);
        tick();
        flush = 1'b0;
        chk("flush_valid", 32'(stg_valid), 32'hC);
        chk("flush_cnt1",  32'(flush_cnt), 32'h1);
        chk("flush_ctrl0", 32'(stg_ctrl[0]), 32'h0);
        chk("flush_ctrl2", 32'(stg_ctrl[2]), 32'(C_C));
        chk("flush_ctrl3", 32'(stg_ctrl[3]), 32'(C_B));

        // Refill, then stall three cycles, then stall+flush
        issue(C_F, 3'd6, 1'b0, 1'b0, 3'd0, 3'd0, 2'b00); tick();
        issue(C_G, 3'd6, 1'b0, 1'b0, 3'd0, 3'd0, 2'b00); tick();
        issue(C_H, 3'd6, 1'b0, 1'b0, 3'd0, 3'd0, 2'b00); tick();
        issue(C_I, 3'd6, 1'b0, 1'b0, 3'd0, 3'd0, 2'b00); tick();
        chk("refill_valid",  32'(stg_valid), 32'hF);
        chk("refill_retire", 32'(retire_cnt), 32'd7);
        issue(C_J, 3'd6, 1'b0, 1'b0, 3'd0, 3'd0, 2'b00);
        stall = 1'b1;
        #1;
        chk("stall_ready", 32'(in_ready), 32'h0);
        repeat (3) tick();
        chk("stall_ctrl0",  32'(stg_ctrl[0]), 32'(C_I));
        chk("stall_ctrl3",  32'(stg_ctrl[3]), 32'(C_F));
        chk("stall_valid",  32'(stg_valid), 32'hF);
        chk("stall_retire", 32'(retire_cnt), 32'd7);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("sflush_valid",  32'(stg_valid), 32'hC);
        chk("sflush_ctrl2",  32'(stg_ctrl[2]), 32'(C_G));
        chk("sflush_ctrl3",  32'(stg_ctrl[3]), 32'(C_F));
        chk("sflush_cnt",    32'(flush_cnt), 32'h2);
        chk("sflush_retire", 32'(retire_cnt), 32'd7);
        stall = 1'b0;

        // Asynchronous reset mid-cycle, then first instruction after release
        tick();
        chk("pre_rst_retire", 32'(retire_cnt), 32'd8);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_valid",  32'(stg_valid), 32'h0);
        chk("arst_ctrl3",  32'(stg_ctrl[3]), 32'h0);
        chk("arst_retire", 32'(retire_cnt), 32'h0);
        chk("arst_flush",  32'(flush_cnt), 32'h0);
        chk("arst_bubble", 32'(bubble_cnt), 32'h0);
        #2;
        reset_n = 1'b1;
        issue(C_K, 3'd7, 1'b0, 1'b0, 3'd0, 3'd0, 2'b00);
        tick();
        chk("post_rst_valid", 32'(stg_valid), 32'h1);
        chk("post_rst_ctrl0", 32'(stg_ctrl[0]), 32'(C_K));

        // Retire counter saturation: E edges of continuous issue give E-4 retirements
        reset_n = 1'b0;
        #4;
        reset_n = 1'b1;
        issue(C_K, 3'd7, 1'b0, 1'b0, 3'd0, 3'd0, 2'b00);
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_pre",   32'(retire_cnt), 32'h0000FFFA);
        repeat (5) tick();
        chk("sat_hit",   32'(retire_cnt), 32'h0000FFFF);
        repeat (3) tick();
        chk("sat_hold",  32'(retire_cnt), 32'h0000FFFF);
        chk("sat_bubble", 32'(bubble_cnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
